// File: rtl/rotation_parser_pkg.sv
// Shared constants and state types for the rotation line parser and coprocessor sequencer.
package rotation_parser_pkg;

    localparam int CP_W = 128;

    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    // P_IDLE: awaiting direction letter | P_DIGITS: accumulating | P_SKIP: discarding malformed line
    typedef enum logic [1:0] {P_IDLE, P_DIGITS, P_SKIP} parse_state_t;

    // S_READY: may pop | S_LOAD: cp_din settling | S_FIRE: strobe | S_HOLD: coprocessor loop time
    typedef enum logic [1:0] {S_READY, S_LOAD, S_FIRE, S_HOLD} seq_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/rotation_parser_if.sv
// UART byte input and coprocessor/status output bundle of the rotation parser.
interface rotation_parser_if;
    import rotation_parser_pkg::*;

    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [CP_W-1:0] cp_din;
    logic            cp_din_valid;
    logic [15:0]     line_count;
    logic [15:0]     err_count;
    logic            overflow;

    modport master (
        output rx_data, rx_valid,
        input  cp_din, cp_din_valid, line_count, err_count, overflow
    );

    modport slave (
        input  rx_data, rx_valid,
        output cp_din, cp_din_valid, line_count, err_count, overflow
    );

endinterface

// File: rtl/rotation_fifo.sv
// Small synchronous FIFO; a push is accepted when full if a pop happens in the same cycle.
module rotation_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         push_ok,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rotation_parser.sv
// Parses L<n>/R<n> rotation lines (LF-terminated) into signed deltas and feeds them to the
// coprocessor one at a time, leaving GAP idle cycles after each strobe.
module rotation_parser
   import rotation_parser_pkg::*;
#(
   parameter int MAX_DIGITS = 9,
   parameter int GAP        = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   rotation_parser_if.slave  bus
);
   localparam int NW = $clog2(MAX_DIGITS + 1);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   parse_state_t  p_state, p_next;
   logic [31:0]   acc, acc_next;
   logic [NW-1:0] ndig, ndig_next;
   logic          neg, neg_next;
   logic          push, err_inc;
   logic [31:0]   push_val;

   seq_state_t    s_state, s_next;
   logic [GW-1:0] gap_cnt, gap_next;
   logic          pop;
   logic [31:0]   cp_val;

   logic [31:0]   head;
   logic          push_ok, fifo_full, fifo_empty;
   logic [15:0]   line_count, err_count;
   logic          overflow;

   assign push_val = neg ? (32'd0 - acc) : acc;

   rotation_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (32)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_val),
      .pop       (pop),
      .pop_data  (head),
      .push_ok   (push_ok),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      p_next    = p_state;
      acc_next  = acc;
      ndig_next = ndig;
      neg_next  = neg;
      push      = 1'b0;
      err_inc   = 1'b0;
      if (bus.rx_valid && (bus.rx_data != CH_CR)) begin
         case (p_state)
            P_IDLE: begin
               if (bus.rx_data == CH_L || bus.rx_data == CH_R) begin
                  p_next    = P_DIGITS;
                  neg_next  = (bus.rx_data == CH_L);
                  acc_next  = '0;
                  ndig_next = '0;
               end else if (bus.rx_data != CH_LF) begin
                  p_next = P_SKIP;
               end
            end
            P_DIGITS: begin
               if (is_digit(bus.rx_data)) begin
                  if (ndig == NW'(MAX_DIGITS)) begin
                     p_next = P_SKIP;
                  end else begin
                     acc_next  = (acc << 3) + (acc << 1) + {28'd0, bus.rx_data[3:0]};
                     ndig_next = ndig + NW'(1);
                  end
               end else if (bus.rx_data == CH_LF) begin
                  p_next = P_IDLE;
                  if (ndig != '0) begin
                     push = 1'b1;
                  end else begin
                     err_inc = 1'b1;
                  end
               end else begin
                  p_next = P_SKIP;
               end
            end
            P_SKIP: begin
               if (bus.rx_data == CH_LF) begin
                  p_next  = P_IDLE;
                  err_inc = 1'b1;
               end
            end
            default: p_next = P_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_state    <= P_IDLE;
         acc        <= '0;
         ndig       <= '0;
         neg        <= 1'b0;
         line_count <= '0;
         err_count  <= '0;
         overflow   <= 1'b0;
      end else begin
         p_state <= p_next;
         acc     <= acc_next;
         ndig    <= ndig_next;
         neg     <= neg_next;
         if (err_inc) begin
            err_count <= err_count + 16'd1;
         end
         if (push_ok) begin
            line_count <= line_count + 16'd1;
         end
         if (push && !push_ok) begin
            overflow <= 1'b1;
         end
      end
   end

   always_comb begin
      s_next   = s_state;
      gap_next = gap_cnt;
      pop      = 1'b0;
      case (s_state)
         S_READY: begin
            if (!fifo_empty && gap_cnt == '0) begin
               pop    = 1'b1;
               s_next = S_LOAD;
            end
         end
         S_LOAD: s_next = S_FIRE;
         S_FIRE: begin
            gap_next = GW'(GAP);
            s_next   = (GAP == 0) ? S_READY : S_HOLD;
         end
         S_HOLD: begin
            if (gap_cnt != '0) begin
               gap_next = gap_cnt - GW'(1);
            end
            if (gap_cnt <= GW'(1)) begin
               s_next = S_READY;
            end
         end
         default: s_next = S_READY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_state <= S_READY;
         gap_cnt <= '0;
         cp_val  <= '0;
      end else begin
         s_state <= s_next;
         gap_cnt <= gap_next;
         if (pop) begin
            cp_val <= head;
         end
      end
   end

   // Strobe decoded from state so an async reset in LOAD/FIRE kills it immediately.
   assign bus.cp_din       = {{(CP_W-32){1'b0}}, cp_val};
   assign bus.cp_din_valid = (s_state == S_FIRE);
   assign bus.line_count   = line_count;
   assign bus.err_count    = err_count;
   assign bus.overflow     = overflow;

endmodule

// File: tb/tb_rotation_parser.sv
// Directed self-checking bench for rotation_parser: per-line vector table plus multi-cycle corner sequences.
// In line strings, '~' stands for LF and '^' stands for CR.
module tb_rotation_parser;
   import rotation_parser_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rotation_parser_if bus();

   rotation_parser #(
      .MAX_DIGITS (9),
      .GAP        (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int          cyc = 0;
   int          strobe_cnt = 0;
   logic [31:0] last_val, last_prev, prev_lo;
   logic        last_upper_zero;
   int          strobe_t[$];
   logic [31:0] strobe_v[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.cp_din_valid) begin
         strobe_cnt++;
         last_val        = bus.cp_din[31:0];
         last_prev       = prev_lo;
         last_upper_zero = (bus.cp_din[127:32] == '0);
         strobe_t.push_back(cyc);
         strobe_v.push_back(bus.cp_din[31:0]);
      end
      prev_lo = bus.cp_din[31:0];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
   endtask

   task automatic send_line(input string s);
      logic [7:0] c;
      for (int k = 0; k < s.len(); k++) begin
         c = s[k];
         if (c == 8'h7E)      c = CH_LF;
         else if (c == 8'h5E) c = CH_CR;
         send_byte(c);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.rx_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      string       line;
      int          strobes;
      logic [31:0] val;
      int          err_inc;
      int          line_inc;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs[NV];

   initial begin
      int          s0, b0;
      logic [15:0] e0, l0;

      vecs[0]  = '{"L68~",          1, 32'hFFFF_FFBC, 0, 1};
      vecs[1]  = '{"R48^~",         1, 32'h0000_0030, 0, 1};
      vecs[2]  = '{"~",             0, 32'h0,         0, 0};
      vecs[3]  = '{"X12~",          0, 32'h0,         1, 0};
      vecs[4]  = '{"L~",            0, 32'h0,         1, 0};
      vecs[5]  = '{"R1234567890~",  0, 32'h0,         1, 0};
      vecs[6]  = '{"R0~",           1, 32'h0000_0000, 0, 1};
      vecs[7]  = '{"L007~",         1, 32'hFFFF_FFF9, 0, 1};
      vecs[8]  = '{"R999999999~",   1, 32'h3B9A_C9FF, 0, 1};
      vecs[9]  = '{"RL5~",          0, 32'h0,         1, 0};
      vecs[10] = '{"^^R12^~",       1, 32'h0000_000C, 0, 1};

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);

      check("rst_cp_din",   64'(|bus.cp_din), 64'd0);
      check("rst_valid",    64'(bus.cp_din_valid), 64'd0);
      check("rst_lines",    64'(bus.line_count), 64'd0);
      check("rst_errs",     64'(bus.err_count), 64'd0);
      check("rst_overflow", 64'(bus.overflow), 64'd0);
      check("rst_pstate",   64'(dut.p_state), 64'(P_IDLE));
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         s0 = strobe_cnt;
         e0 = bus.err_count;
         l0 = bus.line_count;
         send_line(vecs[i].line);
         idle(45);
         check($sformatf("v%0d_strobes", i), 64'(strobe_cnt - s0), 64'(vecs[i].strobes));
         if (vecs[i].strobes > 0) begin
            check($sformatf("v%0d_value", i), 64'(last_val), 64'(vecs[i].val));
            check($sformatf("v%0d_value_pre", i), 64'(last_prev), 64'(vecs[i].val));
            check($sformatf("v%0d_upper0", i), 64'(last_upper_zero), 64'd1);
         end
         check($sformatf("v%0d_err_delta", i), 64'(16'(bus.err_count - e0)), 64'(vecs[i].err_inc));
         check($sformatf("v%0d_line_delta", i), 64'(16'(bus.line_count - l0)), 64'(vecs[i].line_inc));
         check($sformatf("v%0d_pidle", i), 64'(dut.p_state), 64'(P_IDLE));
      end
      check("vec_overflow", 64'(bus.overflow), 64'd0);

      // Reset while the sequencer sits in LOAD: the pending strobe must not appear.
      do_reset();
      s0 = strobe_cnt;
      send_line("R7~");
      idle(1);
      @(negedge clk);
      check("load_state", 64'(dut.s_state), 64'(S_LOAD));
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(30);
      check("load_rst_strobes", 64'(strobe_cnt - s0), 64'd0);
      check("load_rst_cp_din",  64'(|bus.cp_din), 64'd0);
      check("load_rst_lines",   64'(bus.line_count), 64'd0);

      // Six back-to-back lines against a 4-entry FIFO with GAP=16.
      do_reset();
      s0 = strobe_cnt;
      b0 = strobe_t.size();
      for (int n = 1; n <= 6; n++) begin
         send_byte(CH_R);
         send_byte(8'(CH_0 + 8'(n)));
         send_byte(CH_LF);
      end
      idle(150);
      check("burst_strobes",  64'(strobe_cnt - s0), 64'd5);
      check("burst_overflow", 64'(bus.overflow), 64'd1);
      check("burst_lines",    64'(bus.line_count), 64'd5);
      check("burst_errs",     64'(bus.err_count), 64'd0);
      for (int k = 0; k < 5; k++) begin
         if (b0 + k < strobe_t.size()) begin
            check($sformatf("burst_val%0d", k), 64'(strobe_v[b0+k]), 64'(k + 1));
            if (k > 0)
               check($sformatf("burst_gap%0d", k), 64'(strobe_t[b0+k] - strobe_t[b0+k-1]), 64'd19);
         end
      end

      // Reset in the middle of a line discards it.
      do_reset();
      check("rst_clears_overflow", 64'(bus.overflow), 64'd0);
      s0 = strobe_cnt;
      send_line("L12");
      @(negedge clk);
      bus.rx_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send_line("R5~");
      idle(40);
      check("midrst_strobes", 64'(strobe_cnt - s0), 64'd1);
      check("midrst_value",   64'(last_val), 64'd5);
      check("midrst_lines",   64'(bus.line_count), 64'd1);
      check("midrst_errs",    64'(bus.err_count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rotation_parser.md
ROTATION_PARSER -- requirements
Module: rotation_parser

Interface
REQ-001 Parameter MAX_DIGITS, default 9: max decimal digits per rotation line.
REQ-002 Parameter GAP, default 16: idle cycles enforced after each cp_din_valid pulse (coprocessor loop time).
REQ-003 Parameter FIFO_DEPTH, default 4: parsed-value buffer entries (power of two).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx_data  input  8  ASCII byte from UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe, rx_data valid this cycle.
REQ-008 cp_din  output  128  {96'b0, signed 32-bit rotation delta} to coprocessor din.
REQ-009 cp_din_valid  output  1  one-cycle strobe to coprocessor din_valid.
REQ-010 line_count  output  16  count of lines accepted into FIFO, wraps at 65535->0.
REQ-011 err_count  output  16  count of malformed lines, wraps.
REQ-012 overflow  output  1  sticky: a parsed value was dropped because FIFO was full.

Function
REQ-013 Parser FSM states: IDLE, DIGITS, SKIP; one byte consumed per rx_valid cycle, no backpressure.
REQ-014 Byte 0x0D SHALL be ignored in every state.
REQ-015 IDLE: 'L' (0x4C) -> DIGITS, sign negative, acc=0, ndig=0; 'R' (0x52) -> DIGITS, sign positive; 0x0A -> stay IDLE, no count change; any other byte -> SKIP.
REQ-016 DIGITS: '0'..'9' -> acc = acc*10 + digit, ndig+1; a digit arriving with ndig==MAX_DIGITS -> SKIP.
REQ-017 DIGITS: 0x0A with ndig>=1 -> push (sign ? -acc : acc) as 32-bit two's complement, -> IDLE; with ndig==0 -> err_count+1, -> IDLE.
REQ-018 DIGITS: any other byte -> SKIP.
REQ-019 SKIP: discard bytes until 0x0A, then err_count+1, -> IDLE; err_count increments exactly once per malformed line.
REQ-020 Leading zeros legal and count toward ndig; "R0" pushes 0.
REQ-021 Push when FIFO full: value dropped, overflow<=1, line_count unchanged.
REQ-022 line_count increments in the cycle the push is accepted.
REQ-023 Output sequencer states: READY, LOAD, FIRE, HOLD.
REQ-024 READY: FIFO non-empty and gap counter zero -> pop head into cp_din[31:0], -> LOAD.
REQ-025 LOAD -> FIRE next cycle; cp_din_valid=1 only in FIRE (cp_din stable >=1 cycle before and during strobe).
REQ-026 FIRE -> HOLD, gap counter loaded with GAP; HOLD decrements to 0 then -> READY; GAP=0 skips HOLD.
REQ-027 cp_din holds last popped value until next pop; cp_din[127:32] always 0.
REQ-028 Simultaneous push and pop in one cycle SHALL both succeed, including when FIFO full (pop frees slot).
REQ-029 Minimum spacing between cp_din_valid pulses = GAP+3 cycles.

Reset
REQ-030 rst asserted: parser->IDLE, sequencer->READY, FIFO empty, acc=0, cp_din=0, cp_din_valid=0, line_count=0, err_count=0, overflow=0, gap counter=0.
REQ-031 Reset mid-line discards the partial line with no count change; reset during LOAD/FIRE suppresses the pending strobe.

Structure
REQ-032 Shared package holds ASCII constants (CH_L, CH_R, CH_LF, CH_CR, CH_0, CH_9), parser and sequencer state enums, 128-bit cp_din width.
REQ-033 FIFO SHALL be a sub-module rotation_fifo (synchronous, full/empty flags, same clk/rst).
REQ-034 Multiply-by-10 SHALL be (acc<<3)+(acc<<1), no multiplier.

Verification
REQ-035 "L68\n" -> one strobe, cp_din[31:0]=0xFFFFFFBC, line_count=1.
REQ-036 "R48\r\n" then "\n" -> one strobe cp_din[31:0]=0x00000030, CR and empty line ignored, err_count=0.
REQ-037 "X12\n", "L\n", "R1234567890\n" -> no strobes, err_count=3, parser IDLE after each.
REQ-038 Six lines "R1\n".."R6\n" back-to-back at one byte/cycle, GAP=16 -> four buffered plus one popped, overflow=1, strobe values in order, strobes spaced exactly 19 cycles.
REQ-039 Reset asserted after "L12" (no LF), then "R5\n" -> single strobe value 5, line_count=1.
REQ-040 Strobe check: cp_din equals value in cycle before and cycle of cp_din_valid; "R0\n" -> strobe with value 0.
